// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and boot status of the program loader.
// master is the loader side; slave is the byte source / memory / CPU side.
interface imem_loader_if #(
  parameter int AW = 32,
  parameter int IW = 32
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [IW-1:0] wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  modport master (
    input  in_valid, in_data,
    output in_ready, we, waddr, wdata, cpu_rst, done, err
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, we, waddr, wdata, cpu_rst, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: parses a little-endian word count, assembles 32-bit words from bytes,
// writes them into instruction memory and releases the CPU reset once the image is complete.
module imem_loader #(
  parameter int            AW          = 32,
  parameter int            IW          = 32,
  parameter logic [AW-1:0] BASE        = '0,
  parameter int            DEPTH_WORDS = 1024
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.master bus
);
  localparam logic [2:0] S_HDR  = 3'd0;
  localparam logic [2:0] S_CHK  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [31:0] DEPTH_N = 32'(DEPTH_WORDS);

  logic [2:0]    state_q, state_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   n_q, n_d;
  logic [31:0]   word_idx_q, word_idx_d;
  logic [23:0]   buf_q, buf_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [IW-1:0] wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          in_ready;
  logic          accept;

  assign in_ready = rst && ((state_q == S_HDR) || (state_q == S_DATA));
  assign accept   = in_ready && bus.in_valid;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    buf_d      = buf_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_HDR: begin
        if (accept) begin
          n_d[{byte_idx_q, 3'b000} +: 8] = bus.in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = S_CHK;
        end
      end
      S_CHK: begin
        word_idx_d = '0;
        if (n_q == 32'd0)        state_d = S_DONE;
        else if (n_q > DEPTH_N)  state_d = S_ERR;
        else                     state_d = S_DATA;
      end
      S_DATA: begin
        if (accept) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: buf_d[7:0]   = bus.in_data;
            2'd1: buf_d[15:8]  = bus.in_data;
            2'd2: buf_d[23:16] = bus.in_data;
            default: begin
              // Fourth byte completes the word: register the write for the WR cycle.
              we_d    = 1'b1;
              waddr_d = BASE + AW'({word_idx_q, 2'b00});
              wdata_d = {bus.in_data, buf_q};
              state_d = S_WR;
            end
          endcase
        end
      end
      S_WR: begin
        if (word_idx_q == n_q - 32'd1) begin
          state_d = S_DONE;
        end else begin
          word_idx_d = word_idx_q + 32'd1;
          state_d    = S_DATA;
        end
      end
      default: state_d = state_q;
    endcase

    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_HDR;
      byte_idx_q <= '0;
      n_q        <= '0;
      word_idx_q <= '0;
      buf_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      buf_q      <= buf_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Status outputs are forced low for the whole time reset is held, not just after the edge.
  assign bus.in_ready = in_ready;
  assign bus.we       = we_q && rst;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.done     = done_q && rst;
  assign bus.cpu_rst  = done_q && rst;
  assign bus.err      = err_q && rst;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances (BASE 0 and 0x100) share one byte stream.
module tb_imem_loader;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE1 = 32'h100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         err_ok = 1'b0;

  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  logic [31:0] img[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_loader_if #(.AW(32), .IW(32)) bus0 ();
  imem_loader_if #(.AW(32), .IW(32)) bus1 ();

  assign bus0.in_valid = in_valid;
  assign bus0.in_data  = in_data;
  assign bus1.in_valid = in_valid;
  assign bus1.in_data  = in_data;

  imem_loader #(.AW(32), .IW(32), .BASE(32'h0), .DEPTH_WORDS(DEPTH)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  imem_loader #(.AW(32), .IW(32), .BASE(BASE1), .DEPTH_WORDS(DEPTH)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitors: pop expected writes, check release timing.
  logic        done0_prev = 1'b0, crst0_prev = 1'b0, err0_prev = 1'b0, wrote0 = 1'b0;
  logic        done1_prev = 1'b0, crst1_prev = 1'b0, wrote1 = 1'b0;
  int          last_we0 = 0, last_we1 = 0;
  logic [31:0] last_addr1 = '0;

  always @(negedge clk) begin
    logic [63:0] e;
    if (bus0.we) begin
      if (exp_q0.size() == 0) check("we0_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q0.pop_front();
        check("waddr0", bus0.waddr, e[63:32]);
        check("wdata0", bus0.wdata, e[31:0]);
      end
      last_we0 = cyc;
      wrote0   = 1'b1;
    end
    if (bus0.cpu_rst && !crst0_prev) begin
      check("cpu_rst0_with_done", 32'(bus0.done), 32'd1);
      check("cpu_rst0_pending", 32'(exp_q0.size()), 32'd0);
    end
    if (bus0.done && !done0_prev && wrote0) check("done0_latency", 32'(cyc - last_we0), 32'd1);
    if (bus0.err && !err0_prev) check("err0_unexpected", 32'(err_ok), 32'd1);
    done0_prev = bus0.done;
    crst0_prev = bus0.cpu_rst;
    err0_prev  = bus0.err;
    if (!rst) wrote0 = 1'b0;
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (bus1.we) begin
      if (exp_q1.size() == 0) check("we1_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q1.pop_front();
        check("waddr1", bus1.waddr, e[63:32]);
        check("wdata1", bus1.wdata, e[31:0]);
      end
      last_we1   = cyc;
      last_addr1 = bus1.waddr;
      wrote1     = 1'b1;
    end
    if (bus1.cpu_rst && !crst1_prev) begin
      check("cpu_rst1_with_done", 32'(bus1.done), 32'd1);
      check("cpu_rst1_pending", 32'(exp_q1.size()), 32'd0);
    end
    if (bus1.done && !done1_prev && wrote1) check("done1_latency", 32'(cyc - last_we1), 32'd1);
    done1_prev = bus1.done;
    crst1_prev = bus1.cpu_rst;
    if (!rst) wrote1 = 1'b0;
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus0.in_ready), 32'd0);
    check("rst_we",       32'(bus0.we),       32'd0);
    check("rst_waddr",    bus0.waddr,         32'd0);
    check("rst_wdata",    bus0.wdata,         32'd0);
    check("rst_cpu_rst",  32'(bus0.cpu_rst),  32'd0);
    check("rst_done",     32'(bus0.done),     32'd0);
    check("rst_err",      32'(bus0.err),      32'd0);
    rst = 1'b1;
  endtask

  function automatic int gap_for(input int mode, input int k);
    if (mode == 0) return 0;
    return ((k % 2) == 1 ? 1 : 0) + (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
  endfunction

  // Offer one byte and hold it until a handshake edge; in_ready is stable between rising edges.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    if (gap > 0) idle(gap);
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      rdy = bus0.in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        in_valid = 1'b0;
        return;
      end
    end
    check("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic load_image(input logic [31:0] n, input int data_bytes, input int mode);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gap_for(mode, i));
    for (int i = 0; i < data_bytes; i++) begin
      w = img[i/4];
      if ((i % 4) == 0 && (i + 3) < data_bytes) begin
        exp_q0.push_back({32'(4 * (i/4)), w});
        exp_q1.push_back({BASE1 + 32'(4 * (i/4)), w});
      end
      send_byte(w[8*(i%4) +: 8], gap_for(mode, i));
    end
  endtask

  task automatic wait_end(input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (bus0.done || bus0.err) return;
    end
    check("end_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_ignored(input string tag, input int ncyc);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      check(tag, 32'(bus0.in_ready), 32'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_final(input string tag, input logic d, input logic e);
    @(negedge clk);
    check({tag, "_done0"},    32'(bus0.done),    32'(d));
    check({tag, "_cpu_rst0"}, 32'(bus0.cpu_rst), 32'(d));
    check({tag, "_err0"},     32'(bus0.err),     32'(e));
    check({tag, "_done1"},    32'(bus1.done),    32'(d));
    check({tag, "_q0_empty"}, 32'(exp_q0.size()), 32'd0);
    check({tag, "_q1_empty"}, 32'(exp_q1.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);

    // Normal load, back-to-back bytes.
    do_reset();
    img.delete();
    img.push_back(32'h0000_0013);
    img.push_back(32'h0010_0093);
    load_image(32'd2, 8, 0);
    wait_end(20);
    check_final("normal", 1'b1, 1'b0);

    // Same image through a stalling source.
    do_reset();
    load_image(32'd2, 8, 1);
    wait_end(20);
    check_final("stalled", 1'b1, 1'b0);

    // Empty image releases the CPU immediately.
    do_reset();
    img.delete();
    load_image(32'd0, 0, 0);
    wait_end(20);
    check_final("empty", 1'b1, 1'b0);
    check_ignored("empty_in_ready", 4);

    // Oversize header is rejected and the loader locks up.
    do_reset();
    err_ok = 1'b1;
    load_image(32'(DEPTH + 1), 0, 0);
    wait_end(20);
    check_final("oversize", 1'b0, 1'b1);
    check_ignored("err_in_ready", 8);
    check("err_cpu_rst_held", 32'(bus0.cpu_rst), 32'd0);

    // Reset mid-load, then a fresh single-word image.
    do_reset();
    err_ok = 1'b0;
    img.delete();
    img.push_back(32'h1111_1111);
    img.push_back(32'h2222_2222);
    img.push_back(32'h3333_3333);
    load_image(32'd3, 6, 0);
    do_reset();
    check("midrst_q0_empty", 32'(exp_q0.size()), 32'd0);
    img.delete();
    img.push_back(32'hDEAD_BEEF);
    load_image(32'd1, 4, 0);
    wait_end(20);
    check_final("midrst", 1'b1, 1'b0);

    // Fill the whole memory.
    do_reset();
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back(32'(i) * 32'h9E37_79B9 + 32'h13);
    load_image(32'(DEPTH), DEPTH * 4, 0);
    wait_end(20);
    check_final("fill", 1'b1, 1'b0);
    check("fill_last_addr", last_addr1, BASE1 + 32'(4 * (DEPTH - 1)));
    check_ignored("fill_post_done", 6);
    check("fill_done_held", 32'(bus1.done), 32'd1);

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader upstream of the instruction memory. Receives a byte stream (4-byte little-endian word count, then instruction bytes), assembles 32-bit little-endian words and issues one write per word into instruction memory. Holds the CPU in reset until the whole image is written, then releases it. Sits between the host/serial byte source and the `inst_mem` write port plus the CPU reset input.

## Interface
- `AW`, 32: address width.
- `IW`, 32: instruction width; fixed at 32, since four bytes make one word.
- `BASE`, 32'h0: byte address of the first instruction word.
- `DEPTH_WORDS`, 1024: instruction memory capacity in words.

- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `in_valid` input 1: byte source has a byte.
- `in_data` input 8: byte payload.
- `in_ready` output 1: loader accepts a byte. A transfer occurs on an edge with `in_valid && in_ready`.
- `we` output 1: instruction memory write strobe, one cycle per word.
- `waddr` output AW: byte address of the write, word-aligned.
- `wdata` output IW: instruction word.
- `cpu_rst` output 1: active-low reset to the CPU. Low until the load completes.
- `done` output 1: image fully written.
- `err` output 1: header rejected.

## Operation
- States: HDR, CHK, DATA, WR, DONE, ERR. Reset state is HDR.
- Reset values, while `rst`=0 and after reset: `in_ready`=0, `we`=0, `waddr`=0, `wdata`=0, `cpu_rst`=0, `done`=0, `err`=0. Byte index, word index and N are cleared.
- **`in_ready`**: equals (state==HDR or state==DATA) and `rst`=1. It is 0 in CHK, WR, DONE and ERR.
- **HDR**:
  - Collect 4 bytes into N, little-endian (first byte goes to N[7:0]).
  - After the 4th byte, go to CHK.
- **CHK** (one cycle):
  - N==0: go to DONE.
  - N>DEPTH_WORDS: go to ERR.
  - Otherwise: go to DATA with word index 0.
- **DATA**:
  - Collect 4 bytes into the word buffer, little-endian (first byte goes to `wdata[7:0]`).
  - After the 4th byte, go to WR.
- **WR** (one cycle):
  - `we`=1, `waddr`=BASE+4*index, `wdata`=the assembled word.
  - If index==N-1, go to DONE. Otherwise increment the index and go to DATA.
- **DONE**: `done`=1, `cpu_rst`=1. Held until `rst`. Further `in_valid` is ignored because `in_ready`=0.
- **ERR**: `err`=1, `cpu_rst`=0. Held until `rst`. No writes occur.
- `waddr` arithmetic is modulo 2^AW. With BASE word-aligned, `waddr[1:0]` is always 0.
- `we`, `waddr` and `wdata` are registered. `waddr` and `wdata` are don't-care when `we`=0, but hold their last values.
- Bytes offered while `in_ready`=0 are not consumed. The source must hold them stable.
- Reset mid-load returns to HDR:
  - Words already written stay in memory.
  - `cpu_rst` stays low until a complete new image has loaded.

## Timing
- A byte accepted at edge t advances the byte counter at t. Gaps in `in_valid` stall without losing data.
- Last header byte at edge t: CHK is the state during cycle t..t+1. DATA, DONE or ERR is entered at edge t+1, and `in_ready` is high again from edge t+1 when the next state is DATA.
- 4th data byte at edge t:
  - `we`=1 during cycle t..t+1, and memory captures the write at edge t+1.
  - `in_ready`=0 during that cycle.
  - `in_ready` returns high after t+1, unless this was the final word.
- Throughput: at most 1 word per 5 cycles.
- Final write captured at edge t+1: `done` and `cpu_rst` go high at edge t+1, visible in the following cycle. The CPU's first fetch therefore sees every word.
- Total load latency with back-to-back bytes: 5 cycles for the header and CHK, then 5 cycles per word.

## Test plan
- **Normal load.** Stimulus: reset, then the stream 02 00 00 00 | 13 00 00 00 | 93 00 10 00.
  - Exactly two `we` pulses: (waddr=0x0, wdata=0x00000013) and (0x4, 0x00100093).
  - Then `done`=1 and `cpu_rst`=1.
  - `err`=0 throughout.
- **Stalled source.** Stimulus: same image with `in_valid` toggling every other cycle and random gaps up to 7 cycles.
  - Identical writes.
  - No byte is consumed while `in_ready`=0.
- **Empty and oversize headers.**
  - Header N=0: `done`=1, `cpu_rst`=1, no `we`.
  - Header N=DEPTH_WORDS+1: `err`=1, `cpu_rst`=0, no `we`, `in_ready`=0 forever.
- **Reset mid-load.** Stimulus: N=3, drop `rst` for one cycle after the 6th data byte, then send a full image with N=1, word 0xDEADBEEF.
  - Exactly one write before the reset, at 0x0.
  - After the reset, a single write (0x0, 0xDEADBEEF).
  - `cpu_rst` stays low until that write completes.
- **Boundary fill.** Stimulus: `BASE`=0x100, N=DEPTH_WORDS.
  - The last write is at 0x100+4*(DEPTH_WORDS-1).
  - `done` is asserted exactly 1 cycle after that write.
  - Post-`done` bytes are ignored.
